// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_if
// Description : Push/pop handshake bundle between the adder, the ALU result
//               stage and the register-file / writeback consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if;

    // Upstream (adder side) push channel
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_op1;
    logic [7:0] in_op2;
    logic [3:0] in_select;
    logic [7:0] in_result;

    // Downstream (writeback side) pop channel
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [4:0] out_flags;

    // Stage side: consumes the push channel, produces the pop channel
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_op1,
        input  in_op2,
        input  in_select,
        input  in_result,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_flags
    );

    // Environment side: produces pushes, consumes pops
    modport master (
        output in_valid,
        input  in_ready,
        output in_op1,
        output in_op2,
        output in_select,
        output in_result,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_flags
    );

endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered output stage behind the add/sub/inc/dec adder.
//               Computes {E,V,C,N,Z} status flags from the captured operands,
//               select and result, queues result+flags in a DEPTH-entry FIFO
//               with valid/ready handshaking, and keeps a saturating count of
//               accepted signed-overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int DEPTH     = 2,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_stage_if.slave    bus,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_PINC = c_AW'(1);

    localparam logic [3:0] c_SEL_NONE = 4'b0000;
    localparam logic [3:0] c_SEL_ADD  = 4'b0001;
    localparam logic [3:0] c_SEL_SUB  = 4'b0010;
    localparam logic [3:0] c_SEL_INC  = 4'b0100;
    localparam logic [3:0] c_SEL_DEC  = 4'b1000;

    localparam logic [OVF_CNT_W-1:0] c_OVF_MAX = '1;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [7:0]           r_mem_result [DEPTH];
    logic [4:0]           r_mem_flags  [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [7:0]           r_out_result;
    logic [4:0]           r_out_flags;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [8:0]      w_sum;
    logic            w_z;
    logic            w_n;
    logic            w_c;
    logic            w_v;
    logic            w_e;
    logic [4:0]      w_flags;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_count_next;
    logic [c_AW-1:0] w_wr_ptr_next;
    logic [c_AW-1:0] w_rd_ptr_next;
    logic [7:0]      w_head_result;
    logic [4:0]      w_head_flags;

    // 9-bit sum of the operands; bit 8 is the unsigned carry out for add
    assign w_sum = {1'b0, bus.in_op1} + {1'b0, bus.in_op2};

    // Status flag derivation from the values presented by the adder
    always_comb begin
        w_z = (bus.in_result == 8'h00);
        w_n = bus.in_result[7];
        w_c = 1'b0;
        w_v = 1'b0;
        w_e = 1'b0;
        case (bus.in_select)
            c_SEL_ADD: begin
                w_c = w_sum[8];
                w_v = (bus.in_op1[7] == bus.in_op2[7]) &&
                      (bus.in_result[7] != bus.in_op1[7]);
            end
            c_SEL_SUB: begin
                // Carry is "no borrow" for subtraction
                w_c = (bus.in_op1 >= bus.in_op2);
                w_v = (bus.in_op1[7] != bus.in_op2[7]) &&
                      (bus.in_result[7] != bus.in_op1[7]);
            end
            c_SEL_INC: begin
                w_c = (bus.in_op1 == 8'hFF);
                w_v = (bus.in_op1 == 8'h7F);
            end
            c_SEL_DEC: begin
                w_c = (bus.in_op1 != 8'h00);
                w_v = (bus.in_op1 == 8'h80);
            end
            c_SEL_NONE: begin
                // Adder disabled: only Z/N from the forced result
            end
            default: begin
                // More than one select bit set: flag it, suppress C/V
                w_e = 1'b1;
            end
        endcase
        w_flags = {w_e, w_v, w_c, w_n, w_z};
    end

    // Handshake qualifiers; ready/valid are registered so a push never
    // lands on a full FIFO and a pop never comes from an empty one
    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = r_out_valid && bus.out_ready;

    // Next occupancy and pointer values
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_ONE;
            2'b01:   w_count_next = r_count - c_ONE;
            default: w_count_next = r_count;
        endcase
        w_wr_ptr_next = w_push ? (r_wr_ptr + c_PINC) : r_wr_ptr;
        w_rd_ptr_next = w_pop  ? (r_rd_ptr + c_PINC) : r_rd_ptr;
    end

    // Select the entry that will be at the head after this cycle; when the
    // FIFO goes or stays empty the previous head value is retained
    always_comb begin
        w_head_result = r_out_result;
        w_head_flags  = r_out_flags;
        if (w_count_next != '0) begin
            if ((r_count == '0) || ((r_count == c_ONE) && w_pop)) begin
                // The only remaining entry is the one being pushed now
                w_head_result = bus.in_result;
                w_head_flags  = w_flags;
            end else begin
                w_head_result = r_mem_result[w_rd_ptr_next];
                w_head_flags  = r_mem_flags[w_rd_ptr_next];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // FIFO storage write; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= bus.in_result;
            r_mem_flags[r_wr_ptr]  <= w_flags;
        end
    end

    // Pointers, occupancy and registered handshake status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_in_ready  <= (w_count_next != c_FULL);
            r_out_valid <= (w_count_next != '0);
        end
    end

    // Registered head entry presented to the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_result <= 8'h00;
            r_out_flags  <= 5'b0_0000;
        end else begin
            r_out_result <= w_head_result;
            r_out_flags  <= w_head_flags;
        end
    end

    // Saturating count of accepted entries carrying signed overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_push && w_v && (r_ovf_count != c_OVF_MAX)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_flags  = r_out_flags;
    assign ovf_count      = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Scoreboard bench for alu_result_stage. The driver pushes the
//               hand-computed {result, flags} of each accepted vector into a
//               queue; an independent monitor pops and compares on every
//               output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int c_DEPTH     = 2;
    localparam int c_OVF_CNT_W = 2;
    localparam logic [c_OVF_CNT_W-1:0] c_OVF_MAX = '1;

    typedef struct packed {
        logic [7:0] res;
        logic [4:0] flags;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [c_OVF_CNT_W-1:0] ovf_count;
    logic [c_OVF_CNT_W-1:0] exp_ovf;
    exp_t                   sb_q [$];
    int                     n_cmp;
    int                     n_err;

    alu_result_stage_if bus ();

    alu_result_stage #(
        .DEPTH     (c_DEPTH),
        .OVF_CNT_W (c_OVF_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .ovf_count (ovf_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison with failure report
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector until accepted; record its expected output
    task automatic send(input logic [7:0] op1, input logic [7:0] op2, input logic [3:0] sel,
                        input logic [7:0] res, input logic [4:0] exp_flags);
        int   n;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_op1    = op1;
        bus.in_op2    = op2;
        bus.in_select = sel;
        bus.in_result = res;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck low for result 0x%0h", res);
        end else begin
            e.res   = res;
            e.flags = exp_flags;
            sb_q.push_back(e);
            if (exp_flags[3] && exp_ovf != c_OVF_MAX) exp_ovf = exp_ovf + 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
    endtask

    // Let the consumer take everything expected, bounded in cycles
    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // Monitor: compare head entry on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got result 0x%0h flags 0x%0h, expected no entry",
                             bus.out_result, bus.out_flags);
                end else begin
                    e = sb_q.pop_front();
                    chk("pop_result", 32'(bus.out_result), 32'(e.res));
                    chk("pop_flags", 32'(bus.out_flags), 32'(e.flags));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        n_cmp         = 0;
        n_err         = 0;
        exp_ovf       = '0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op1    = 8'h00;
        bus.in_op2    = 8'h00;
        bus.in_select = 4'b0000;
        bus.in_result = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset / idle state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'h00);
        chk("rst_out_flags", 32'(bus.out_flags), 32'h00);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);

        // Add with signed overflow, visible the cycle after the push
        bus.out_ready = 1'b1;
        send(8'h7F, 8'h01, 4'b0001, 8'h80, 5'b01010);
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        chk("latency_out_result", 32'(bus.out_result), 32'h80);
        drain();

        // Sub to zero, then dec from zero
        send(8'h05, 8'h05, 4'b0010, 8'h00, 5'b00101);
        send(8'h00, 8'h00, 4'b1000, 8'hFF, 5'b00010);
        drain();

        // Backpressure fills the FIFO; third offer must be ignored
        bus.out_ready = 1'b0;
        send(8'h10, 8'h01, 4'b0001, 8'h11, 5'b00000);
        chk("bp_ready_one_entry", 32'(bus.in_ready), 32'd1);
        send(8'h30, 8'h0E, 4'b0010, 8'h22, 5'b00100);
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_valid_full", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_op1    = 8'h30;
        bus.in_op2    = 8'h03;
        bus.in_select = 4'b0001;
        bus.in_result = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head_oldest", 32'(bus.out_result), 32'h11);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
        drain();

        // Simultaneous push and pop with one entry held
        bus.out_ready = 1'b0;
        send(8'h41, 8'h00, 4'b0100, 8'h42, 5'b00000);
        bus.out_ready = 1'b1;
        send(8'hF0, 8'h20, 4'b0001, 8'h10, 5'b00100);
        bus.out_ready = 1'b0;
        chk("pp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pp_in_ready", 32'(bus.in_ready), 32'd1);
        chk("pp_head_result", 32'(bus.out_result), 32'h10);
        drain();

        // Multi-hot select and disabled adder
        send(8'h01, 8'h01, 4'b0011, 8'h02, 5'b10000);
        send(8'h00, 8'h00, 4'b0000, 8'h00, 5'b00001);
        drain();

        // Overflow counter saturation (count already 1)
        send(8'h7F, 8'h00, 4'b0100, 8'h80, 5'b01010);
        send(8'h80, 8'h00, 4'b1000, 8'h7F, 5'b01100);
        send(8'h80, 8'h80, 4'b0001, 8'h00, 5'b01101);
        send(8'h80, 8'h01, 4'b0010, 8'h7F, 5'b01100);
        drain();
        chk("ovf_saturated", 32'(ovf_count), 32'd3);

        // Reset with entries queued
        bus.out_ready = 1'b0;
        send(8'h01, 8'h02, 4'b0001, 8'h03, 5'b00000);
        send(8'h02, 8'h02, 4'b0001, 8'h04, 5'b00000);
        chk("prerst_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        exp_ovf = '0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ovf_count", 32'(ovf_count), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_result", 32'(bus.out_result), 32'h00);
        rst = 1'b0;

        // Traffic resumes normally after reset
        bus.out_ready = 1'b1;
        send(8'h7F, 8'h7F, 4'b0001, 8'hFE, 5'b01010);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the combined add/sub/inc/dec adder.
- Captures the 8-bit adder result together with the operands and the 4-bit one-hot select that produced it.
- Derives status flags (zero, negative, carry, signed overflow, select error) and buffers result+flags in a small FIFO with valid/ready handshake toward the register file / writeback logic.
- Keeps a saturating count of signed-overflow events.

Parameters:
DEPTH, 2, FIFO entries; power of two, minimum 2.
OVF_CNT_W, 8, width of the saturating overflow counter.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents op1/op2/select/result
in_ready  output  1  stage can accept an entry this cycle
in_op1  input  8  operand 1 as applied to the adder
in_op2  input  8  operand 2 as applied to the adder
in_select  input  4  one-hot op: bit0 add, bit1 sub, bit2 inc, bit3 dec
in_result  input  8  adder result
out_valid  output  1  head entry available
out_ready  input  1  downstream accepts head entry
out_result  output  8  head entry result
out_flags  output  5  head entry flags {E,V,C,N,Z} (bit4..bit0)
ovf_count  output  OVF_CNT_W  saturating count of accepted entries with V=1

Behaviour:
- Reset: synchronous, active-high; clk and rst as above. On rst, FIFO emptied and pointers zeroed.
  - Outputs after reset: out_valid=0, out_result=0x00, out_flags=5'b0, ovf_count=0, in_ready=1.
  - rst mid-operation discards all stored entries that cycle, with no handshake completion.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !full, registered from occupancy; no combinational path from out_ready.
  - Push and pop in the same cycle are both honoured when not full and not empty; occupancy unchanged.
  - When full, in_ready=0 even if out_ready=1 that cycle.
- Latency: an entry pushed in cycle n is visible at out_* in cycle n+1. There is no same-cycle bypass.
- out_result/out_flags always reflect the head entry. When empty, they hold the last popped value (or the reset value); they are not valid when out_valid=0.
- Flags are computed combinationally at input from the captured values and stored with the entry:
  - Z = (in_result==0).
  - N = in_result[7].
  - Add: C = carry out of op1+op2 (9-bit sum bit 8); V = (op1[7]==op2[7]) && (res[7]!=op1[7]).
  - Sub: C = no-borrow = (op1 >= op2) unsigned; V = (op1[7]!=op2[7]) && (res[7]!=op1[7]).
  - Inc: C = (op1==0xFF); V = (op1==0x7F).
  - Dec: C = (op1!=0x00); V = (op1==0x80).
  - select==4'b0000 (adder disabled, result forced 0): entry accepted, C=V=E=0, Z/N from in_result.
  - Multi-hot select: E=1, C=V=0, Z/N from in_result. The entry is still stored.
- in_result is not checked against the operands; flags use the given result for Z/N/V.
- ovf_count: increments on each push with V=1 and saturates at all-ones. Pops do not affect it.
- Full/empty: pointers wrap modulo DEPTH. An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty. Pop when empty and push when full are impossible by construction.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, out_flags=0, ovf_count=0.
- Add: push op1=0x7F, op2=0x01, sel=0001, res=0x80, out_ready=1 → next cycle out_valid=1, out_result=0x80, flags E0 V1 C0 N1 Z0; ovf_count=1.
- Sub: op1=0x05, op2=0x05, sel=0010, res=0x00 → Z=1, C=1, N=0, V=0. Then dec: op1=0x00, sel=1000, res=0xFF → N=1, C=0, V=0.
- Backpressure, out_ready=0, DEPTH=2: push 0x11 then 0x22 → in_ready=0 after the second push; a third in_valid is ignored. Raise out_ready → pops 0x11 then 0x22 in order, and in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop with one entry held → occupancy stays 1, order preserved. Multi-hot sel=0011 → E=1, C=V=0. sel=0000, res=0 → Z=1, E=0.
- Overflow saturation with OVF_CNT_W=2: four V=1 pushes → count reads 3 and holds. Assert rst with 2 entries queued → next cycle out_valid=0, ovf_count=0, in_ready=1.
